// File: rtl/calc_pipe_pkg.sv
// Shared types for the parallel calculation stage: lane identifiers and the
// default operand width, used by the dispatcher and the collecting mux.
package calc_pipe_pkg;

    localparam int CALC_W = 32;

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_t;

    function automatic lane_t other_lane(input lane_t l);
        return (l == LANE0) ? LANE1 : LANE0;
    endfunction

endpackage

// File: rtl/calc_tag_fifo.sv
// Order-tag FIFO: records which lane received each item so the collector
// can restore input order. Wrap-bit pointers distinguish full from empty.
module calc_tag_fifo
    import calc_pipe_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  logic  pop,
    input  lane_t din,
    output lane_t head,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    lane_t       mem_q [DEPTH];
    lane_t       mem_d [DEPTH];
    logic        do_push, do_pop;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    // Full blocks a push even when a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        if (do_push) mem_d[wr_ptr_q[AW-1:0]] = din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= LANE0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/calc_dispatch_1to2.sv
// Registered 1-to-2 round-robin dispatcher with order-tag FIFO.
// Define CALC_DISPATCH_SKIP_EN for work-conserving dispatch past a stalled lane.
module calc_dispatch_1to2
    import calc_pipe_pkg::*;
#(
    parameter int M         = CALC_W,
    parameter int TAG_DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [M-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [M-1:0] out0_data,
    output logic         out0_valid,
    input  logic         out0_ready,
    output logic [M-1:0] out1_data,
    output logic         out1_valid,
    input  logic         out1_ready,
    output lane_t        sel_tag,
    output logic         sel_valid,
    input  logic         sel_pop,
    output logic         busy
);

    logic [1:0][M-1:0] data_q, data_d;
    logic [1:0]        vld_q, vld_d;
    logic [1:0]        lane_rdy, lane_free, load;
    lane_t             next_lane_q, next_lane_d;
    lane_t             target;
    logic              accept, tag_full, tag_empty;

    assign lane_rdy  = {out1_ready, out0_ready};
    assign lane_free = ~vld_q | lane_rdy;

    always_comb begin
        target = next_lane_q;
`ifdef CALC_DISPATCH_SKIP_EN
        if (!lane_free[next_lane_q] && lane_free[other_lane(next_lane_q)])
            target = other_lane(next_lane_q);
`endif
    end

    assign in_ready = lane_free[target] && !tag_full;
    assign accept   = in_valid && in_ready;
    assign load     = !accept ? 2'b00 : (target == LANE1) ? 2'b10 : 2'b01;

    always_comb begin
        data_d      = data_q;
        vld_d       = vld_q & ~lane_rdy;
        next_lane_d = next_lane_q;
        for (int x = 0; x < 2; x++) begin
            // A drain and a reload in the same cycle keep the lane full.
            if (load[x]) begin
                data_d[x] = in_data;
                vld_d[x]  = 1'b1;
            end
        end
        if (accept) next_lane_d = other_lane(target);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= '0;
            vld_q       <= '0;
            next_lane_q <= LANE0;
        end else begin
            data_q      <= data_d;
            vld_q       <= vld_d;
            next_lane_q <= next_lane_d;
        end
    end

    calc_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .pop   (sel_pop),
        .din   (target),
        .head  (sel_tag),
        .full  (tag_full),
        .empty (tag_empty)
    );

    assign out0_data  = data_q[0];
    assign out1_data  = data_q[1];
    assign out0_valid = vld_q[0];
    assign out1_valid = vld_q[1];
    assign sel_valid  = !tag_empty;
    assign busy       = |vld_q || !tag_empty;

endmodule

// File: doc/calc_dispatch_1to2.md
# calc_dispatch_1to2

Registered 1-to-2 dispatcher at the head of the parallel calculation stage: it takes one operand stream and distributes items alternately to two identical calc lanes, using valid/ready handshakes on every side. For every item it also records which lane received it in an order-tag FIFO. The collecting mux at the tail of the stage pops this FIFO to drive its lane select, so results leave the stage in input order.

## Interface

Parameters:
- M, 32, data bit width
- TAG_DEPTH, 8, order-tag FIFO depth; power of two, at least 2

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  M  operand from upstream
- in_valid  in  1  in_data valid
- in_ready  out  1  dispatcher accepts this cycle
- out0_data / out1_data  out  M  operand to lane 0 / lane 1
- out0_valid / out1_valid  out  1  lane output valid
- out0_ready / out1_ready  in  1  lane accepts
- sel_tag  out  1  lane (0/1) of the oldest outstanding item
- sel_valid  out  1  tag FIFO not empty
- sel_pop  in  1  collector consumed the current tag
- busy  out  1  any lane valid or tag FIFO not empty

## Operation

- Accept condition: in_valid && in_ready.
- in_ready = lane_free(target) && !tag_full.
  - lane_free(x) = !outx_valid || outx_ready. This gives a combinational ready path from outx_ready.
- target is next_lane. next_lane is a 1-bit round-robin pointer, reset to 0.
- On accept:
  - outx_data <= in_data and outx_valid <= 1 for x = target.
  - Push target into the tag FIFO.
  - next_lane <= !target.
- Lane register without a new load: it clears outx_valid when outx_ready is high. It holds data and valid stable while outx_valid && !outx_ready.
- A lane register may be reloaded in the same cycle it is drained (full throughput per lane).
- Tag FIFO:
  - Read and write pointers are log2(TAG_DEPTH)+1 bits, with a wrap bit.
  - full when the pointers are equal except for the MSB. empty when the pointers are fully equal.
  - sel_tag is the entry at the read pointer.
  - A pop occurs when sel_pop && sel_valid. sel_pop while empty is ignored.
  - Push and pop in the same cycle are legal when not full. When full, push is blocked even if a pop occurs in that cycle.
- Arithmetic: data is passed through unmodified, with no width change. Pointers wrap modulo 2·TAG_DEPTH.
- Reset (asynchronous, immediate, including mid-transfer):
  - out0_valid = out1_valid = 0, out0_data = out1_data = 0.
  - next_lane = 0, tag FIFO empty, sel_valid = 0, sel_tag = 0, busy = 0.
  - Items in flight are discarded.

## Timing

- Latency is 1 cycle: an item accepted at edge n shows outx_valid = 1 and its tag (if the FIFO was empty) after edge n.
- Peak throughput is one item per cycle. With both lanes always ready, the lanes alternate 0,1,0,1…
- in_ready depends combinationally on outx_ready and the registered state only. It never depends on in_valid.
- sel_valid and sel_tag are registered state (FIFO output). sel_pop takes effect at the next edge.
- If a lane stalls in strict mode, in_ready stays low until that lane drains, even if the other lane is free.

## Configuration

- CALC_DISPATCH_SKIP_EN
  - Defined: work-conserving dispatch. If lane next_lane is not free and the other lane is free, target = the other lane. next_lane <= !target in all cases.
  - Undefined: strict alternation as above.
- In both modes the tag FIFO records the actual target lane, so ordering is preserved.

## Structure

- Package calc_pipe_pkg holds:
  - typedef lane_t (1-bit enum LANE0/LANE1), shared with the collecting mux.
  - The default data width constant CALC_W = 32.
- Sub-module calc_tag_fifo: a synchronous FIFO of lane_t entries with push, pop, full, empty and head ports, parameterised by depth. The dispatcher instantiates one.

## Test plan

- Reset: assert rst_n = 0 mid-stream with both lanes valid → all valids, sel_valid and busy drop to 0 immediately, with no clock edge needed. After release, the first item goes to lane 0.
- Streaming: both lanes ready, in_data = 1..6 on consecutive cycles → out0 carries 1,3,5 and out1 carries 2,4,6, each one cycle after accept. Tags are 0,1,0,1,0,1.
- Lane stall (strict): hold out1_ready = 0 with in_valid = 1 continuously → item 2 stays on out1_data and remains stable. in_ready drops once lane 1 is the target. The stream resumes the cycle after out1_ready = 1.
- Lane stall (SKIP_EN defined): same stimulus → items 3 and 4 both go to lane 0. Tags are 0,1,0,0.
- Tag FIFO full: TAG_DEPTH = 8, sel_pop = 0, lanes always ready, 10 items offered → exactly 8 accepted and in_ready = 0. With a sel_pop in the full cycle, no push occurs that cycle. The next push is accepted one cycle later.
- Pop while empty: sel_pop = 1 with no items → sel_valid stays 0 and the pointers are unchanged. The first subsequent push gives sel_tag = 0 and sel_valid = 1.
